// File: rtl/fp_int_pkg.sv
// Shared constants and types for the FP16 x INT4 MAC datapath (multiplier and accumulator).
package fp_int_pkg;

  localparam int unsigned EXP_WIDTH   = 5;
  localparam int unsigned MANT_WIDTH  = 15;
  localparam int unsigned EXP_BIAS    = 25;
  localparam int unsigned ACC_WIDTH   = 32;
  localparam int unsigned FRAC_BITS   = 8;
  localparam int unsigned CNT_WIDTH   = 8;

  // Two extra bits keep the signed shift (exp - bias + frac) in range without wrap.
  localparam int unsigned SHIFT_WIDTH = EXP_WIDTH + 2;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
  } prod_t;

  // Signed left-shift amount that places a product at the accumulator's binary point.
  function automatic logic signed [SHIFT_WIDTH-1:0] align_shift(input logic [EXP_WIDTH-1:0] exp);
    return SHIFT_WIDTH'(exp) + SHIFT_WIDTH'(FRAC_BITS) - SHIFT_WIDTH'(EXP_BIAS);
  endfunction

endpackage

// File: rtl/fp_int_acc_if.sv
// Product-beat input and group-result output channels of the accumulator.
interface fp_int_acc_if;
  import fp_int_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sign;
  logic [EXP_WIDTH-1:0]  in_exp;
  logic [MANT_WIDTH-1:0] in_mant;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic [CNT_WIDTH-1:0]  out_count;
  logic                  out_sat;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_sat
  );

endinterface

// File: rtl/fp_int_align.sv
// Converts a sign/exponent/magnitude product into a two's-complement fixed-point value.
module fp_int_align
  import fp_int_pkg::*;
(
  input  prod_t                       prod,
  output logic signed [ACC_WIDTH-1:0] value
);

  logic signed [SHIFT_WIDTH-1:0] shift;
  logic        [SHIFT_WIDTH-1:0] amount;
  logic        [ACC_WIDTH-1:0]   mag;

  // Right shifts truncate toward zero on the magnitude, before the sign is applied.
  always_comb begin
    shift  = align_shift(prod.exp);
    amount = shift[SHIFT_WIDTH-1] ? SHIFT_WIDTH'(-shift) : SHIFT_WIDTH'(shift);
    if (shift[SHIFT_WIDTH-1]) begin
      mag = ACC_WIDTH'(prod.mant) >> amount;
    end else begin
      mag = ACC_WIDTH'(prod.mant) << amount;
    end
    value = prod.sign ? -$signed(mag) : $signed(mag);
  end

endmodule

// File: rtl/fp_int_acc.sv
// Dot-product reduction: aligns product beats, sums a group with saturation, emits the total.
module fp_int_acc
  import fp_int_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  fp_int_acc_if.slave bus
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  acc_state_e            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  al_q, al_d;
  logic                  al_v, al_v_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  sat_q, sat_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  prod_t                       prod;
  logic signed [ACC_WIDTH-1:0] aligned;
  logic        [ACC_WIDTH:0]   sum;
  logic                        hs_in;
  logic                        hs_out;

  assign prod = '{sign: bus.in_sign, exp: bus.in_exp, mant: bus.in_mant};

  fp_int_align u_align (
    .prod  (prod),
    .value (aligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      al_q        <= '0;
      al_v        <= 1'b0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      al_q        <= al_d;
      al_v        <= al_v_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, accumulate and handshake logic; ready/valid are registered from the next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    al_d    = al_q;
    al_v_d  = 1'b0;
    count_d = count_q;
    sat_d   = sat_q;

    hs_in  = bus.in_valid && in_ready_q;
    hs_out = out_valid_q && bus.out_ready;
    sum    = {acc_q[ACC_WIDTH-1], acc_q} + {al_q[ACC_WIDTH-1], al_q};

    // Sign disagreement between the two top bits of the widened sum means overflow.
    if (al_v) begin
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_WIDTH-1:0];
      end
    end

    unique case (state_q)
      ACCUM: begin
        if (hs_in) begin
          al_d   = aligned;
          al_v_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
          if (bus.in_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        if (hs_out) begin
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == OUT);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_fp_int_acc.sv
// Randomised self-checking bench for fp_int_acc against an arithmetic reference model.
module tb_fp_int_acc;
  import fp_int_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bit   bs [300];
  int   be [300];
  int   bm [300];

  fp_int_acc_if bus ();

  fp_int_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value = (-1)^s * m * 2^(e - bias), scaled by 2^FRAC_BITS and truncated toward zero.
  function automatic longint align_ref(input bit s, input int e, input int m);
    int     sh;
    longint mag;
    sh = e - int'(EXP_BIAS) + int'(FRAC_BITS);
    if (sh >= 0) mag = longint'(m) * (longint'(1) << sh);
    else         mag = longint'(m) / (longint'(1) << (-sh));
    return s ? -mag : mag;
  endfunction

  function automatic void model_group(input int n, output logic [ACC_WIDTH-1:0] d,
                                      output logic [CNT_WIDTH-1:0] c, output logic s);
    longint sum;
    longint hi;
    longint lo;
    hi  = (longint'(1) << (ACC_WIDTH - 1)) - 1;
    lo  = -(longint'(1) << (ACC_WIDTH - 1));
    sum = 0;
    s   = 1'b0;
    for (int i = 0; i < n; i++) begin
      sum = sum + align_ref(bs[i], be[i], bm[i]);
      if (sum > hi) begin sum = hi; s = 1'b1; end
      else if (sum < lo) begin sum = lo; s = 1'b1; end
    end
    d = ACC_WIDTH'(sum);
    c = (n > 255) ? CNT_WIDTH'(255) : CNT_WIDTH'(n);
  endfunction

  task automatic set_beat(input int i, input bit last);
    bus.in_sign = bs[i];
    bus.in_exp  = EXP_WIDTH'(be[i]);
    bus.in_mant = MANT_WIDTH'(bm[i]);
    bus.in_last = last;
  endtask

  // Streams bs/be/bm[0..n-1] back-to-back, waits for the result, optionally stalls, then accepts it.
  task automatic drive_group(input int n, input int hold, input bit early,
                             output logic [ACC_WIDTH-1:0] d, output logic [CNT_WIDTH-1:0] c,
                             output logic s, output int lat, output bit rdy_ok, output bit bp_ok);
    rdy_ok = 1'b1;
    bp_ok  = 1'b1;
    bus.out_ready = early;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      set_beat(i, i == n - 1);
      if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (bus.in_ready !== 1'b0) bp_ok = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
    d = bus.out_data;
    c = bus.out_count;
    s = bus.out_sat;
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'($urandom_range(0, 1));
        bus.in_exp   = EXP_WIDTH'($urandom_range(0, 31));
        bus.in_mant  = MANT_WIDTH'($urandom_range(1, 32767));
        bus.in_last  = 1'b1;
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== d ||
            bus.out_count !== c || bus.out_sat !== s) bp_ok = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bp_ok = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_count !== '0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); end
    checks++; if (bus.out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%b exp=0", bus.out_sat); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [ACC_WIDTH-1:0] d; logic [CNT_WIDTH-1:0] c; logic s; int lat; bit r; bit b;
    bs[0] = 1; be[0] = 17; bm[0] = 8640;
    drive_group(1, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (d !== 32'hFFFFDE40) begin failures++; $display("FAIL single_data got=%h exp=ffffde40", d); end
    checks++; if (c !== 8'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", c); end
    checks++; if (s !== 1'b0) begin failures++; $display("FAIL single_sat got=%b exp=0", s); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", lat); end
    checks++; if (b !== 1'b1) begin failures++; $display("FAIL single_handshake got=%b exp=1", b); end
  endtask

  task automatic test_back_to_back();
    logic [ACC_WIDTH-1:0] d; logic [CNT_WIDTH-1:0] c; logic s; int lat; bit r; bit b;
    bs[0] = 0; be[0] = 15; bm[0] = 1024;
    bs[1] = 0; be[1] = 15; bm[1] = 1024;
    bs[2] = 1; be[2] = 17; bm[2] = 8640;
    drive_group(3, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (d !== 32'hFFFFE040) begin failures++; $display("FAIL b2b_data got=%h exp=ffffe040", d); end
    checks++; if (c !== 8'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", c); end
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_zero();
    logic [ACC_WIDTH-1:0] d; logic [CNT_WIDTH-1:0] c; logic s; int lat; bit r; bit b;
    bs[0] = 0; be[0] = 0; bm[0] = 1;
    drive_group(1, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL underflow_data got=%h exp=0", d); end
    bs[0] = 1; be[0] = 15; bm[0] = 0;
    drive_group(1, 0, 1'b1, d, c, s, lat, r, b);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL neg_zero_data got=%h exp=0", d); end
    checks++; if (c !== 8'd1) begin failures++; $display("FAIL neg_zero_count got=%0d exp=1", c); end
  endtask

  task automatic test_saturation();
    logic [ACC_WIDTH-1:0] d; logic [CNT_WIDTH-1:0] c; logic s; int lat; bit r; bit b;
    for (int i = 0; i < 5; i++) begin bs[i] = 0; be[i] = 31; bm[i] = 32767; end
    drive_group(5, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (d !== 32'h7FFFFFFF) begin failures++; $display("FAIL sat_data got=%h exp=7fffffff", d); end
    checks++; if (s !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", s); end
    for (int i = 0; i < 5; i++) begin bs[i] = 1; be[i] = 31; bm[i] = 32767; end
    drive_group(5, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (d !== 32'h80000000) begin failures++; $display("FAIL negsat_data got=%h exp=80000000", d); end
    checks++; if (s !== 1'b1) begin failures++; $display("FAIL negsat_flag got=%b exp=1", s); end
    bs[0] = 0; be[0] = 15; bm[0] = 1024;
    drive_group(1, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (d !== 32'h00000100) begin failures++; $display("FAIL after_sat_data got=%h exp=00000100", d); end
    checks++; if (s !== 1'b0) begin failures++; $display("FAIL after_sat_flag got=%b exp=0", s); end
  endtask

  task automatic test_backpressure();
    logic [ACC_WIDTH-1:0] d; logic [CNT_WIDTH-1:0] c; logic s; int lat; bit r; bit b;
    bs[0] = 0; be[0] = 15; bm[0] = 1024;
    drive_group(1, 3, 1'b0, d, c, s, lat, r, b);
    checks++; if (b !== 1'b1) begin failures++; $display("FAIL bp_stable got=%b exp=1", b); end
    checks++; if (c !== 8'd1) begin failures++; $display("FAIL bp_count got=%0d exp=1", c); end
    checks++; if (d !== 32'h00000100) begin failures++; $display("FAIL bp_data got=%h exp=00000100", d); end
    drive_group(1, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (c !== 8'd1) begin failures++; $display("FAIL bp_next_count got=%0d exp=1", c); end
  endtask

  task automatic test_reset_mid();
    logic [ACC_WIDTH-1:0] d; logic [CNT_WIDTH-1:0] c; logic s; int lat; bit r; bit b;
    bs[0] = 0; be[0] = 20; bm[0] = 5000;
    bs[1] = 1; be[1] = 18; bm[1] = 300;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      set_beat(i, 1'b0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    checks++; if (bus.out_data !== '0 || bus.out_count !== '0 || bus.out_sat !== 1'b0 ||
                  bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_outputs got data=%h count=%0d sat=%b valid=%b ready=%b exp all reset",
               bus.out_data, bus.out_count, bus.out_sat, bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    bs[0] = 0; be[0] = 15; bm[0] = 1024;
    drive_group(1, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (d !== 32'h00000100) begin failures++; $display("FAIL midreset_data got=%h exp=00000100", d); end
    checks++; if (c !== 8'd1) begin failures++; $display("FAIL midreset_count got=%0d exp=1", c); end
  endtask

  task automatic test_count_saturate();
    logic [ACC_WIDTH-1:0] d, ed; logic [CNT_WIDTH-1:0] c, ec; logic s, es; int lat; bit r; bit b;
    for (int i = 0; i < 260; i++) begin
      bs[i] = 1'($urandom_range(0, 1)); be[i] = 17; bm[i] = int'($urandom_range(0, 100));
    end
    model_group(260, ed, ec, es);
    drive_group(260, 0, 1'b0, d, c, s, lat, r, b);
    checks++; if (c !== ec) begin failures++; $display("FAIL cnt_sat_count got=%0d exp=%0d", c, ec); end
    checks++; if (d !== ed) begin failures++; $display("FAIL cnt_sat_data got=%h exp=%h", d, ed); end
  endtask

  task automatic test_random();
    logic [ACC_WIDTH-1:0] d, ed; logic [CNT_WIDTH-1:0] c, ec; logic s, es; int lat; bit r; bit b;
    int n;
    for (int g = 0; g < 30; g++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        bs[i] = 1'($urandom_range(0, 1));
        be[i] = int'($urandom_range(0, 31));
        bm[i] = int'($urandom_range(0, 32767));
      end
      model_group(n, ed, ec, es);
      drive_group(n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), d, c, s, lat, r, b);
      checks++; if (d !== ed) begin failures++; $display("FAIL rand_data g=%0d got=%h exp=%h", g, d, ed); end
      checks++; if (c !== ec) begin failures++; $display("FAIL rand_count g=%0d got=%0d exp=%0d", g, c, ec); end
      checks++; if (s !== es) begin failures++; $display("FAIL rand_sat g=%0d got=%b exp=%b", g, s, es); end
      checks++; if (lat !== 1 || r !== 1'b1 || b !== 1'b1) begin
        failures++;
        $display("FAIL rand_protocol g=%0d got lat=%0d ready=%b bp=%b exp lat=1 ready=1 bp=1", g, lat, r, b);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_count_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
